// File: rtl/multi_seq.sv
// multi_seq: sequential shift-add multiplier, unsigned or two's-complement.
// Operands are reduced to magnitudes on the accept edge. One partial product
// is added per RUN cycle. The sign is applied once, on the completion edge.
//
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE or DONE).
// That edge latches in1/in2/signed_mode. busy stays high for WIDTH cycles.
// done then pulses for one cycle, and it is the first cycle in which out
// holds the new product. out keeps that value until the next completion.
module multi_seq #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_in1;
  logic [WIDTH-1:0] abs_in2;
  logic [PW-1:0]    add_term;
  logic [PW-1:0]    acc_next;
  logic             last_iter;

  // Accept decode, operand magnitudes and the next accumulator value.
  always_comb begin
    accept    = start && ((state == S_IDLE) || (state == S_DONE));
    sign_a    = signed_mode & in1[WIDTH-1];
    sign_b    = signed_mode & in2[WIDTH-1];
    // Negating -2^(WIDTH-1) yields 2^(WIDTH-1), which is the correct unsigned magnitude.
    abs_in1   = sign_a ? (~in1 + WIDTH'(1)) : in1;
    abs_in2   = sign_b ? (~in2 + WIDTH'(1)) : in2;
    add_term  = mag_b[0] ? ({{WIDTH{1'b0}}, mag_a} << cnt) : '0;
    acc_next  = acc + add_term;
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // FSM, datapath registers and the registered product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            mag_a <= abs_in1;
            mag_b <= abs_in2;
            neg   <= sign_a ^ sign_b;
            acc   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          mag_b <= mag_b >> 1;
          cnt   <= cnt + CW'(1);
          if (last_iter) begin
            // The final iteration's partial product is already in acc_next.
            out   <= neg ? (~acc_next + PW'(1)) : acc_next;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs decode directly from the state.
  always_comb begin
    busy      = (state == S_RUN);
    done      = (state == S_DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_multi_seq.sv
// tb_multi_seq: directed scenarios plus exhaustive and random operands for multi_seq (WIDTH=5).
// Expected products come from integer arithmetic on the operands' numeric values.
module tb_multi_seq;

  localparam int W  = 5;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          signed_mode;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          busy;
  logic          done;
  logic [PW-1:0] out;
  logic [1:0]    state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [PW-1:0] exp_q[$];

  multi_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .state_dbg   (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference product: interpret the operands as integers, multiply, and truncate to PW bits.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sm);
    int x;
    int y;
    int p;
    x = int'(a);
    y = int'(b);
    if (sm && a[W-1]) x = x - (1 << W);
    if (sm && b[W-1]) y = y - (1 << W);
    p = x * y;
    return PW'(p);
  endfunction

  // Driver: one multiply from IDLE, checks latency, busy window, and the product.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    int k;
    bit busy_ok;
    logic [PW-1:0] want;
    @(negedge clk);
    in1 = a; in2 = b; signed_mode = sm; start = 1'b1;
    exp_q.push_back(ref_mul(a, b, sm));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in1 = W'($urandom); in2 = W'($urandom); signed_mode = 1'($urandom);
    k = 0;
    busy_ok = 1'b1;
    while (!done && k < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check("latency", k, W);
    check("busy_window", {31'd0, busy_ok}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    want = exp_q.pop_front();
    check("product", {22'd0, out}, {22'd0, want});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int k;
    int ndone;
    logic [PW-1:0] prev;

    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; in1 = '0; in2 = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom); signed_mode = 1'($urandom);
      in1 = W'($urandom); in2 = W'($urandom);
      #1;
      check("rst_out", {22'd0, out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    idle_cycles(2);

    // Max unsigned, then signed corners.
    do_mul(5'd31, 5'd31, 1'b0);
    check("u31x31", {22'd0, out}, 32'h3C1);
    do_mul(5'h10, 5'h10, 1'b1);
    check("s_m16xm16", {22'd0, out}, 32'h100);
    do_mul(5'h1D, 5'd7, 1'b1);
    check("s_m3x7", {22'd0, out}, 32'h3EB);
    do_mul(5'd0, 5'h10, 1'b1);
    check("s_0xm16", {22'd0, out}, 32'h000);

    // A start during RUN is ignored.
    @(negedge clk);
    in1 = 5'd3; in2 = 5'd4; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);                       // t0
    @(negedge clk); start = 1'b0;
    @(posedge clk);                       // t0+1
    @(negedge clk); in1 = 5'd9; in2 = 5'd9; start = 1'b1;
    @(posedge clk);                       // t0+2, ignored
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (k = 3; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ign_time", k, 5);
        check("ign_out", {22'd0, out}, 32'd12);
      end
    end
    check("ign_ndone", ndone, 1);

    // Back-to-back with start held through the DONE cycle.
    @(negedge clk);
    in1 = 5'd2; in2 = 5'd3; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);                       // t0
    @(negedge clk); in1 = 5'd4; in2 = 5'd5;
    for (k = 1; k <= 13; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6) start = 1'b0;
      check("b2b_done", {31'd0, done}, {31'd0, (k == 5 || k == 11)});
      check("b2b_busy", {31'd0, busy}, {31'd0, (k != 5 && k < 11)});
      if (k >= 5 && k <= 10) check("b2b_out1", {22'd0, out}, 32'd6);
      if (k >= 11) check("b2b_out2", {22'd0, out}, 32'd20);
    end

    // Reset during RUN aborts the operation.
    @(negedge clk);
    in1 = 5'd7; in2 = 5'd7; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);                       // t0
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);            // t0+3
    #2 rst_n = 1'b0;
    #1;
    check("abort_out", {22'd0, out}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort_quiet", ndone, 0);
    do_mul(5'd7, 5'd7, 1'b0);
    check("after_abort", {22'd0, out}, 32'd49);

    // Exhaustive operand pairs in both modes.
    for (int sm = 0; sm < 2; sm++)
      for (int a = 0; a < 32; a++)
        for (int b = 0; b < 32; b++)
          do_mul(W'(a), W'(b), 1'(sm));

    // Random operands with random idle gaps; out must hold between operations.
    for (int i = 0; i < 150; i++) begin
      prev = out;
      idle_cycles($urandom_range(0, 2));
      check("hold", {22'd0, out}, {22'd0, prev});
      do_mul(W'($urandom), W'($urandom), 1'($urandom));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
